ifmap_packet_sched: RTL and testbench
=====================================

// Module: ifmap_packet_sched
// PURPOSE
//  Clocked scheduler for the two-timestep input-feature-map bank. Loads 25x25 one-bit ifmaps for timestep 1 and 2.
//  After load_done, emits 50 NoC packets in order row 0..24, and for each row timestep 1 then timestep 2.
//  Each packet carries one 25-bit ifmap row and source/dest/hop routing fields for the 5-wide mesh.
//  Sits between the testbench/loader and the router port of the ifmap memory node.
// PARAMETERS
//  WIDTH_ADDR    12  width of wr_addr (linear address row*DEPTH_I+col)
//  DEPTH_I       25  ifmap rows = cols = packet payload width
//  NODE          12  1-based label of this node; source field = NODE, source column = (NODE-1)%5
//  WIDTH_PACKET  57  NoC packet width
//  GAP           0   idle cycles, pkt_valid low, inserted after each accepted packet
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             synchronous reset, active-high
//  wr_valid   in   1             load write request
//  wr_ready   out  1             load write accept; equals (state==LOAD)
//  wr_ts      in   1             0 = timestep-1 bank, 1 = timestep-2 bank
//  wr_addr    in   WIDTH_ADDR    linear bit address, row=addr/DEPTH_I, col=addr%DEPTH_I
//  wr_data    in   1             ifmap bit
//  load_done  in   1             single-cycle pulse: loading complete, begin sending
//  pkt_valid  out  1             packet offered to router
//  pkt_ready  in   1             router accepts packet
//  pkt_data   out  WIDTH_PACKET  packet, stable while pkt_valid && !pkt_ready
//  busy       out  1             high in SEND/GAP states
//  done       out  1             one-cycle pulse after 50th packet accepted
// BEHAVIOUR
//  Reset: state=LOAD, row=0, ts=0, gap cnt=0; pkt_valid=0, pkt_data=0, busy=0, done=0; banks NOT cleared.
//  Reset mid-send: drops the current packet (pkt_valid=0 next cycle) and returns to LOAD; bank contents are kept.
//  FSM LOAD -> SEND -> (GAP) -> SEND ... -> DONE -> LOAD.
//  LOAD: write when wr_valid&&wr_ready: bank[wr_ts][row][col] <= wr_data. wr_addr >= DEPTH_I*DEPTH_I: accepted, dropped.
//   load_done in LOAD -> SEND next edge. wr_valid and load_done in the same cycle: write completes, then transition.
//   pkt_data for (row0,ts0) is registered at that same edge, so pkt_valid rises 1 cycle after the load_done cycle.
//  SEND: pkt_valid=1. Handshake on pkt_valid&&pkt_ready.
//   If GAP==0: the next packet is registered on the same edge (1 packet/cycle max).
//   If GAP>0: enter GAP for exactly GAP cycles, then SEND with the next packet.
//   Counters: ts 0->1; then ts 1->0 with row+1. Handshake on (row 24, ts 1) -> DONE.
//  DONE: done=1, pkt_valid=0 for one cycle -> LOAD. Bank contents are kept, so a reload may be partial.
//  load_done outside LOAD: ignored. wr_valid outside LOAD: not accepted (wr_ready=0).
//  Packet format, all unlisted bits zero:
//   [24:0]  = bank[ts][row]  (bit c = col c)
//   dest    = (row<5 ? row : 4) + 5*ts   (0-based, 4 bits)
//   [55:52] = NODE;  [51:48] = dest+1
//   dcol=dest%5, scol=(NODE-1)%5
//   [47]    = dcol>scol
//   [46:44] = |dcol-scol|  (3 bits, no wrap)
//   [42:40] = dest<5 ? 1 : 2;  [56],[43],[39:25] = 0
// TESTING
//  1 All-zero banks, load_done, pkt_ready=1 -> 50 packets on 50 consecutive cycles; first 57'h0C1110000000000.
//    done pulses 1 cycle after the last accept.
//  2 Write ts0 addr 26 data 1, addr 624 data 1; load_done ->
//    pkt#2 (row1,ts0) [24:0]=25'h0000002, [51:48]=2, [47:44]=0, [42:40]=1;
//    pkt#48 (row24,ts0) [24:0]=25'h1000000, [51:48]=5, [47]=1, [46:44]=3.
//  3 Routing: (row0,ts1) -> [51:48]=6, [47]=0, [46:44]=1, [42:40]=2;
//    (row3,ts1) -> [51:48]=9, [47]=1, [46:44]=2, [42:40]=2.
//  4 Backpressure: hold pkt_ready=0 for 7 cycles on pkt#5 -> pkt_valid stays 1 and pkt_data is unchanged;
//    no packet is skipped or duplicated.
//  5 wr_addr=625 in LOAD -> accepted, no bank change. load_done during SEND -> ignored, still exactly 50 packets.
//  6 rst at pkt#20 -> pkt_valid=0, busy=0 next cycle. New load_done (no writes) -> row0 restarts with the old data intact.
//    Repeat with GAP=2: pkt_valid low exactly 2 cycles between accepts.

Source files
------------

// File: rtl/ifmap_packet_sched.sv
// Two-timestep ifmap bank with a NoC packet scheduler: loads 25x25 one-bit maps per timestep,
// then streams one packet per (row, timestep) to the router port of the ifmap memory node.
module ifmap_packet_sched #(
  parameter int unsigned WIDTH_ADDR   = 12,
  parameter int unsigned DEPTH_I      = 25,
  parameter int unsigned NODE         = 12,
  parameter int unsigned WIDTH_PACKET = 57,
  parameter int unsigned GAP          = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic                    i_wr_ts,
  input  logic [WIDTH_ADDR-1:0]   i_wr_addr,
  input  logic                    i_wr_data,
  input  logic                    i_load_done,
  output logic                    o_pkt_valid,
  input  logic                    i_pkt_ready,
  output logic [WIDTH_PACKET-1:0] o_pkt_data,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned ROW_W  = $clog2(DEPTH_I);
  localparam int unsigned N_BITS = DEPTH_I * DEPTH_I;
  localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH_I - 1);
  localparam logic [ROW_W-1:0] MESH_W   = ROW_W'(5);
  localparam logic [2:0]       SCOL     = 3'((NODE - 1) % 5);

  typedef enum logic [1:0] {S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [ROW_W-1:0]   r_row, w_row_nx;
  logic               r_ts, w_ts_nx;
  logic [GAP_W-1:0]   r_gap, w_gap_nx;
  logic               w_load_pkt;

  logic [DEPTH_I-1:0] r_bank [2][DEPTH_I];

  logic               w_wr_en, w_wr_hit;
  logic [ROW_W-1:0]   w_wr_row, w_wr_col;
  logic [DEPTH_I-1:0] w_bits;
  logic [2:0]         w_dcol, w_hops;
  logic [3:0]         w_dest;
  logic               w_east;
  logic [WIDTH_PACKET-1:0] w_pkt;

  // Load-port address decode; out-of-range addresses are accepted but never stored
  assign w_wr_en  = i_wr_valid && o_wr_ready;
  assign w_wr_hit = i_wr_addr < WIDTH_ADDR'(N_BITS);
  assign w_wr_row = ROW_W'(i_wr_addr / WIDTH_ADDR'(DEPTH_I));
  assign w_wr_col = ROW_W'(i_wr_addr % WIDTH_ADDR'(DEPTH_I));

  // Bank storage survives reset so a later load may be partial
  always_ff @(posedge i_clk) begin
    if (w_wr_en && w_wr_hit) begin
      r_bank[i_wr_ts][w_wr_row][w_wr_col] <= i_wr_data;
    end
  end

  // Row payload for the next packet, forwarding a write landing on the same edge as load_done
  always_comb begin
    w_bits = r_bank[w_ts_nx][w_row_nx];
    if (w_wr_en && w_wr_hit && (i_wr_ts == w_ts_nx) && (w_wr_row == w_row_nx)) begin
      w_bits[w_wr_col] = i_wr_data;
    end
  end

  // Routing: rows beyond the mesh width fold onto the last column; timestep selects the mesh row
  always_comb begin
    w_dcol = (w_row_nx < MESH_W) ? 3'(w_row_nx) : 3'd4;
    w_dest = 4'(w_dcol) + (w_ts_nx ? 4'd5 : 4'd0);
    w_east = w_dcol > SCOL;
    w_hops = w_east ? (w_dcol - SCOL) : (SCOL - w_dcol);
    w_pkt             = '0;
    w_pkt[DEPTH_I-1:0] = w_bits;
    w_pkt[55:52]      = 4'(NODE);
    w_pkt[51:48]      = w_dest + 4'd1;
    w_pkt[47]         = w_east;
    w_pkt[46:44]      = w_hops;
    w_pkt[42:40]      = w_ts_nx ? 3'd2 : 3'd1;
  end

  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row;
    w_ts_nx    = r_ts;
    w_gap_nx   = r_gap;
    w_load_pkt = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (i_load_done) begin
          w_state_nx = S_SEND;
          w_row_nx   = '0;
          w_ts_nx    = 1'b0;
          w_load_pkt = 1'b1;
        end
      end
      S_SEND: begin
        // pkt_valid is high for the whole of SEND, so ready alone completes the handshake
        if (i_pkt_ready) begin
          if (r_ts && (r_row == LAST_ROW)) begin
            w_state_nx = S_DONE;
          end else begin
            w_ts_nx    = ~r_ts;
            w_row_nx   = r_ts ? (r_row + 1'b1) : r_row;
            w_load_pkt = 1'b1;
            if (GAP != 0) begin
              w_state_nx = S_GAP;
              w_gap_nx   = GAP_W'(GAP - 1);
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_state_nx = S_SEND;
        end else begin
          w_gap_nx = r_gap - 1'b1;
        end
      end
      S_DONE:  w_state_nx = S_LOAD;
      default: w_state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_LOAD;
      r_row       <= '0;
      r_ts        <= 1'b0;
      r_gap       <= '0;
      o_pkt_data  <= '0;
      o_pkt_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_wr_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_row       <= w_row_nx;
      r_ts        <= w_ts_nx;
      r_gap       <= w_gap_nx;
      if (w_load_pkt) begin
        o_pkt_data <= w_pkt;
      end
      o_pkt_valid <= (w_state_nx == S_SEND);
      o_busy      <= (w_state_nx == S_SEND) || (w_state_nx == S_GAP);
      o_done      <= (w_state_nx == S_DONE);
      o_wr_ready  <= (w_state_nx == S_LOAD);
    end
  end

endmodule

// File: tb/tb_ifmap_packet_sched.sv
// Bench for ifmap_packet_sched: a GAP=0 and a GAP=2 instance share all inputs and are checked
// against an arithmetic packet model built from a shadow copy of the banks.
module tb_ifmap_packet_sched;

  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ts, wr_data, load_done, pr;
  logic [11:0] wr_addr;
  logic        wrdy [2];
  logic        pv   [2];
  logic [56:0] pd   [2];
  logic        bsy  [2];
  logic        dn_o [2];

  int n_vec = 0;
  int n_err = 0;
  bit bm [2][25][25];

  always #5 clk = ~clk;

  ifmap_packet_sched #(.GAP(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wrdy[0]), .i_wr_ts(wr_ts),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_load_done(load_done), .o_pkt_valid(pv[0]),
    .i_pkt_ready(pr), .o_pkt_data(pd[0]), .o_busy(bsy[0]), .o_done(dn_o[0]));

  ifmap_packet_sched #(.GAP(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wrdy[1]), .i_wr_ts(wr_ts),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_load_done(load_done), .o_pkt_valid(pv[1]),
    .i_pkt_ready(pr), .o_pkt_data(pd[1]), .o_busy(bsy[1]), .o_done(dn_o[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packet n in send order: row n/2, timestep n%2
  function automatic logic [56:0] exp_pkt(input int n);
    logic [56:0] p;
    int row, ts, dest, dcol, scol;
    if (n >= 50) return '1;
    p = '0;
    row = n / 2;
    ts  = n % 2;
    for (int c = 0; c < 25; c++) p[c] = bm[ts][row][c];
    dest = ((row < 5) ? row : 4) + 5 * ts;
    dcol = dest % 5;
    scol = (12 - 1) % 5;
    p[55:52] = 4'(12);
    p[51:48] = 4'(dest + 1);
    p[47]    = dcol > scol;
    p[46:44] = 3'((dcol > scol) ? (dcol - scol) : (scol - dcol));
    p[42:40] = (dest < 5) ? 3'd1 : 3'd2;
    return p;
  endfunction

  task automatic wr(input bit ts, input int addr, input bit d);
    @(negedge clk);
    wr_valid = 1'b1; wr_ts = ts; wr_addr = 12'(addr); wr_data = d; load_done = 1'b0;
    if (addr < 625) bm[ts][addr / 25][addr % 25] = d;
  endtask

  task automatic kick(input bit with_w, input bit ts, input int addr, input bit d);
    @(negedge clk);
    load_done = 1'b1;
    wr_valid  = with_w; wr_ts = ts; wr_addr = 12'(addr); wr_data = d;
    if (with_w && addr < 625) bm[ts][addr / 25][addr % 25] = d;
  endtask

  task automatic run_pass(input int rst_at, input bit rand_rdy, input bit stall,
                          input bit junk, input bit chk_first);
    int idx [2];
    int last [2];
    bit waitv [2];
    bit seen [2];
    int stalls;
    int cyc;
    idx = '{0, 0}; last = '{0, 0}; waitv = '{0, 0}; seen = '{0, 0};
    stalls = 0; cyc = 0;
    while (cyc < 1000 && !(seen[0] && seen[1])) begin
      @(negedge clk);
      cyc++;
      load_done = 1'b0;
      wr_valid  = 1'b0;
      if (rst_at >= 0 && idx[0] == rst_at) begin
        rst = 1'b1;
        pr  = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
          chk("rst_pkt_valid", 64'(pv[k]), 64'd0);
          chk("rst_busy", 64'(bsy[k]), 64'd0);
          chk("rst_wr_ready", 64'(wrdy[k]), 64'd1);
        end
        return;
      end
      if (chk_first && cyc == 1) begin
        chk("first_valid", 64'(pv[0]), 64'd1);
        chk("first_pkt", 64'(pd[0]), 64'h0C1110000000000);
      end
      if (stall && idx[0] == 4 && pv[0] && stalls < 7) begin
        pr = 1'b0;
        stalls++;
      end else begin
        pr = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (pv[k]) begin
          chk(k ? "pkt_gap2" : "pkt_gap0", 64'(pd[k]), 64'(exp_pkt(idx[k])));
          chk("busy_in_send", 64'(bsy[k]), 64'd1);
          if (waitv[k]) begin
            chk(k ? "spacing_gap2" : "spacing_gap0", 64'(cyc - last[k]), k ? 64'd3 : 64'd1);
            waitv[k] = 1'b0;
          end
          if (pr) begin
            idx[k]++;
            last[k]  = cyc;
            waitv[k] = 1'b1;
          end
        end
        if (dn_o[k]) begin
          chk("done_count", 64'(idx[k]), 64'd50);
          chk("done_latency", 64'(cyc - last[k]), 64'd1);
          seen[k] = 1'b1;
        end
      end
      if (junk && bsy[0]) begin
        chk("wr_ready_busy", 64'(wrdy[0]), 64'd0);
        load_done = 1'($urandom_range(0, 1));
        wr_valid  = 1'($urandom_range(0, 1));
        wr_ts     = 1'($urandom_range(0, 1));
        wr_addr   = 12'($urandom_range(0, 624));
        wr_data   = 1'($urandom_range(0, 1));
      end
    end
    chk("pass_complete", 64'(seen[0] && seen[1]), 64'd1);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_ts = 1'b0; wr_addr = '0; wr_data = 1'b0;
    load_done = 1'b0; pr = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_wr_ready", 64'(wrdy[k]), 64'd1);
      chk("reset_pkt_valid", 64'(pv[k]), 64'd0);
      chk("reset_pkt_data", 64'(pd[k]), 64'd0);
      chk("reset_busy", 64'(bsy[k]), 64'd0);
      chk("reset_done", 64'(dn_o[k]), 64'd0);
    end
    rst = 1'b0;

    // All-zero banks, free-flowing router
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 625; a++) wr(1'(t), a, 1'b0);
    kick(1'b0, 1'b0, 0, 1'b0);
    run_pass(-1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Directed bits, dropped out-of-range writes, random fill; write coincident with load_done
    wr(1'b0, 26, 1'b1);
    wr(1'b0, 624, 1'b1);
    wr(1'b0, 95, 1'b0);
    wr(1'b0, 625, 1'b1);
    wr(1'b0, 4095, 1'b1);
    wr(1'b1, 650, 1'b1);
    for (int i = 0; i < 80; i++)
      wr(1'($urandom_range(0, 1)), $urandom_range(0, 624), 1'($urandom_range(0, 1)));
    wr(1'b0, 95, 1'b0);
    kick(1'b1, 1'b0, 3, 1'b1);
    run_pass(-1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a send, then resend from the retained banks
    kick(1'b0, 1'b0, 0, 1'b0);
    run_pass(19, 1'b1, 1'b0, 1'b1, 1'b0);
    kick(1'b0, 1'b0, 0, 1'b0);
    run_pass(-1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
